rot4_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 4-bit rotate stage. It accepts nibble rotate commands over a valid/ready handshake and drives the rotate stage's four data bits and 2-bit select. It registers the stage's combinational result and returns it over a second valid/ready handshake. A sweep mode emits all four rotations of one nibble as four consecutive results.

---
 rtl/rot4_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_rot4_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rot4_cmd_sequencer.sv
// rot4_cmd_sequencer: command front-end for an external 4-bit rotate stage.
// Accepts one rotate command at a time, drives the stage from registers,
// captures the stage result and returns it over a valid/ready handshake.
// Sweep mode walks the rotate amount through all four values.
module rot4_cmd_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_data,
    input  logic [1:0]           in_amt,
    input  logic                 in_sweep,
    output logic                 sh_a,
    output logic                 sh_b,
    output logic                 sh_c,
    output logic                 sh_d,
    output logic [1:0]           sh_sel,
    input  logic [3:0]           sh_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_data,
    output logic [1:0]           out_amt,
    output logic                 out_last
);

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   amt_q, amt_d;
    logic            sweep_q, sweep_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_d;
    logic            out_valid_d;
    logic [DW-1:0]   out_data_d;
    logic [AW-1:0]   out_amt_d;
    logic            out_last_d;

    // Rotate stage is fed only from registered command state.
    assign sh_a   = data_q[3];
    assign sh_b   = data_q[2];
    assign sh_c   = data_q[1];
    assign sh_d   = data_q[0];
    assign sh_sel = amt_q;

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            amt_q     <= '0;
            sweep_q   <= 1'b0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            amt_q     <= amt_d;
            sweep_q   <= sweep_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_amt   <= out_amt_d;
            out_last  <= out_last_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        amt_d      = amt_q;
        sweep_d    = sweep_q;
        cnt_d      = cnt_q;
        out_data_d = out_data;
        out_amt_d  = out_amt;
        out_last_d = out_last;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    amt_d   = in_amt;
                    sweep_d = in_sweep;
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_data_d = sh_out;
                out_amt_d  = amt_q;
                out_last_d = !sweep_q || (cnt_q == CW'(3));
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = S_IDLE;
                    end else begin
                        amt_d   = AW'(amt_q + AW'(1));
                        cnt_d   = CW'(cnt_q + CW'(1));
                        state_d = S_CAPTURE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags follow the state being entered.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

endmodule

// File: tb/tb_rot4_cmd_sequencer.sv
// Bench for rot4_cmd_sequencer: models the rotate stage, keeps a queue of
// expected results per accepted command and checks every cycle.
module tb_rot4_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic       in_sweep;
    logic       sh_a, sh_b, sh_c, sh_d;
    logic [1:0] sh_sel;
    logic [3:0] sh_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_amt;
    logic       out_last;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] amt;
        logic       last;
    } res_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   valid_at = 0;
    bit   busy   = 0;
    bit   last_acc = 0;
    logic [3:0] cur_data = '0;
    res_t exp_q[$];
    res_t log_q[$];

    always #5 clk = ~clk;

    // Rotate right by s: the behaviour of the downstream rotate stage.
    function automatic logic [3:0] rotr(input logic [3:0] d, input logic [1:0] s);
        logic [7:0] t;
        t = {d, d} >> s;
        return t[3:0];
    endfunction

    assign sh_out = rotr({sh_a, sh_b, sh_c, sh_d}, sh_sel);

    rot4_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_sweep  (in_sweep),
        .sh_a      (sh_a),
        .sh_b      (sh_b),
        .sh_c      (sh_c),
        .sh_d      (sh_d),
        .sh_sel    (sh_sel),
        .sh_out    (sh_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    // One clock: note handshakes seen by the DUT, advance, update model, check.
    task automatic step();
        bit   r_now, acc, hs;
        logic [3:0] d;
        logic [1:0] a;
        logic       s;
        int         n;
        res_t       obs;
        r_now = rst;
        acc   = !rst && in_valid && in_ready;
        hs    = !rst && out_valid && out_ready;
        d = in_data; a = in_amt; s = in_sweep;
        obs = '{data: out_data, amt: out_amt, last: out_last};
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (r_now) begin
            busy = 0;
            exp_q.delete();
            check("rst_in_ready", 8'(in_ready), 8'd1);
            check("rst_out_valid", 8'(out_valid), 8'd0);
            check("rst_out_data", 8'(out_data), 8'd0);
            check("rst_out_amt", 8'(out_amt), 8'd0);
            check("rst_out_last", 8'(out_last), 8'd0);
            check("rst_sh_sel", 8'(sh_sel), 8'd0);
            check("rst_sh_bits", 8'({sh_a, sh_b, sh_c, sh_d}), 8'd0);
        end else begin
            if (hs) begin
                log_q.push_back(obs);
                if (exp_q.size() == 0) begin
                    check("hs_unexpected", 8'(exp_q.size()), 8'd1);
                end else begin
                    if (exp_q[0].last) busy = 0;
                    else valid_at = cyc + 1;
                    void'(exp_q.pop_front());
                end
            end
            if (acc) begin
                n = s ? 4 : 1;
                for (int k = 0; k < n; k++) begin
                    res_t r;
                    r.amt  = 2'(a + 2'(k));
                    r.data = rotr(d, r.amt);
                    r.last = (k == n - 1);
                    exp_q.push_back(r);
                end
                cur_data = d;
                busy     = 1;
                valid_at = cyc + 1;
            end
        end
        check("in_ready", 8'(in_ready), 8'(!busy));
        check("out_valid", 8'(out_valid), 8'(busy && cyc >= valid_at));
        if (busy && exp_q.size() > 0) begin
            check("sh_bits", 8'({sh_a, sh_b, sh_c, sh_d}), 8'(cur_data));
            check("sh_sel", 8'(sh_sel), 8'(exp_q[0].amt));
            if (cyc >= valid_at) begin
                check("out_data", 8'(out_data), 8'(exp_q[0].data));
                check("out_amt", 8'(out_amt), 8'(exp_q[0].amt));
                check("out_last", 8'(out_last), 8'(exp_q[0].last));
            end
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] a, input logic s);
        bit ok;
        ok = 0;
        in_valid = 1; in_data = d; in_amt = a; in_sweep = s;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = last_acc;
        end
        in_valid = 0;
        check("accept_timeout", 8'(ok), 8'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) step();
        check("idle_timeout", 8'(busy), 8'd0);
    endtask

    task automatic check_sweep(input logic [15:0] datas, input logic [1:0] a0);
        logic [3:0] d;
        check("sweep_count", 8'(log_q.size()), 8'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            d = datas[15 - 4*i -: 4];
            check("sweep_data", 8'(log_q[i].data), 8'(d));
            check("sweep_amt", 8'(log_q[i].amt), 8'(2'(a0 + 2'(i))));
            check("sweep_last", 8'(log_q[i].last), 8'(i == 3));
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_amt = '0; in_sweep = 0; out_ready = 0;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); in_data = 4'($urandom);
            in_amt = 2'($urandom); in_sweep = 1'($urandom); out_ready = 1'($urandom);
            step();
        end
        rst = 0; in_valid = 0; out_ready = 1;
        step();

        // Single rotate.
        log_q.delete();
        send(4'b1000, 2'd1, 1'b0);
        wait_idle(20);
        check("single_count", 8'(log_q.size()), 8'd1);
        if (log_q.size() > 0) begin
            check("single_data", 8'(log_q[0].data), 8'b0100);
            check("single_amt", 8'(log_q[0].amt), 8'd1);
            check("single_last", 8'(log_q[0].last), 8'd1);
        end

        // Sweep from 0, then sweep with wrap.
        log_q.delete();
        send(4'b1000, 2'd0, 1'b1);
        wait_idle(40);
        check_sweep(16'b1000_0100_0010_0001, 2'd0);
        log_q.delete();
        send(4'b1011, 2'd3, 1'b1);
        wait_idle(40);
        check_sweep(16'b0111_1011_1101_1110, 2'd3);

        // Backpressure with a competing command.
        log_q.delete();
        out_ready = 0;
        send(4'b0011, 2'd2, 1'b0);
        in_valid = 1; in_data = 4'b1111; in_amt = 2'd1; in_sweep = 1;
        for (int i = 0; i < 7; i++) step();
        check("bp_held_valid", 8'(out_valid), 8'd1);
        in_valid = 0; out_ready = 1;
        wait_idle(10);
        check("bp_count", 8'(log_q.size()), 8'd1);
        if (log_q.size() > 0) begin
            check("bp_data", 8'(log_q[0].data), 8'b1100);
            check("bp_amt", 8'(log_q[0].amt), 8'd2);
        end

        // Reset while the third sweep result is waiting.
        log_q.delete();
        send(4'b1000, 2'd0, 1'b1);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) step();
        out_ready = 0;
        for (int i = 0; i < 10 && !out_valid; i++) step();
        check("mid_sweep_valid", 8'(out_valid), 8'd1);
        rst = 1;
        step();
        rst = 0;
        out_ready = 1;
        log_q.delete();
        send(4'b0110, 2'd1, 1'b0);
        wait_idle(20);
        check("post_rst_count", 8'(log_q.size()), 8'd1);
        if (log_q.size() > 0) check("post_rst_data", 8'(log_q[0].data), 8'b0011);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = 1'($urandom);
            in_data   = 4'($urandom);
            in_amt    = 2'($urandom);
            in_sweep  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 0; in_valid = 0; out_ready = 1;
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
